// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential ALU.
// SEQ_ALU_SIGNED_MUL_EN (see seq_alu_mul) does not affect anything declared here.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_PASS = 3'b100,
        OP_SHL  = 3'b101,
        OP_MUL  = 3'b110,
        OP_CMP  = 3'b111
    } op_e;

    localparam int unsigned ST_Z = 15;
    localparam int unsigned ST_N = 14;
    localparam int unsigned ST_C = 13;
    localparam int unsigned ST_V = 12;

    typedef enum logic {
        StIdle,
        StMul
    } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one multiplier bit per clock, WIDTH cycles per product.
// SEQ_ALU_SIGNED_MUL_EN: operands are two's complement (magnitudes multiplied, sign restored).
module seq_alu_mul #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_go,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_neg;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_acc_next;

`ifdef SEQ_ALU_SIGNED_MUL_EN
    assign w_a_mag = i_a[WIDTH-1] ? (~i_a + 1'b1) : i_a;
    assign w_b_mag = i_b[WIDTH-1] ? (~i_b + 1'b1) : i_b;
    assign w_neg   = i_a[WIDTH-1] ^ i_b[WIDTH-1];
`else
    assign w_a_mag = i_a;
    assign w_b_mag = i_b;
    assign w_neg   = 1'b0;
`endif

    // The last partial product is folded in combinationally so the result
    // is ready for capture on the WIDTH-th edge after go.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_valid    = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign o_busy     = r_busy;
    assign o_product  = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
        end else if (i_go) begin
            r_busy   <= 1'b1;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_cnt    <= '0;
            r_neg    <= w_neg;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (o_valid) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/ready/done handshake; MUL runs on seq_alu_mul.
// SEQ_ALU_SIGNED_MUL_EN selects a signed multiply inside seq_alu_mul.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic [15:0]      o_status
);

    state_e             r_state;
    logic               r_ready;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [15:0]        r_status;

    op_e                w_op;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic               w_add_v;
    logic               w_sub_v;
    logic [WIDTH-1:0]   w_shl;
    logic [WIDTH-1:0]   w_logic;
    logic               w_go;
    logic               w_mul_busy;
    logic               w_mul_valid;
    logic [2*WIDTH-1:0] w_product;

    assign w_op    = op_e'(i_op);
    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
    assign w_add_v = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
    assign w_sub_v = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
    // Any shift amount bit at or above SHW means b >= WIDTH.
    assign w_shl   = (|(i_b >> SHW)) ? '0 : (i_a << i_b[SHW-1:0]);

    always_comb begin
        w_logic = '0;
        case (w_op)
            OP_AND:  w_logic = i_a & i_b;
            OP_PASS: w_logic = i_b;
            OP_SHL:  w_logic = w_shl;
            default: w_logic = '0;
        endcase
    end

    assign w_go = (r_state == StIdle) && i_start && (w_op == OP_MUL) && !w_mul_busy;

    seq_alu_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_go      (w_go),
        .i_a       (i_a),
        .i_b       (i_b),
        .o_busy    (w_mul_busy),
        .o_valid   (w_mul_valid),
        .o_product (w_product)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_status <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_done <= (w_op != OP_MUL);
                        case (w_op)
                            OP_NOP: r_result <= '0;
                            OP_ADD: begin
                                r_result       <= w_sum[WIDTH-1:0];
                                r_status[ST_Z] <= ~|w_sum[WIDTH-1:0];
                                r_status[ST_N] <= w_sum[WIDTH-1];
                                r_status[ST_C] <= w_sum[WIDTH];
                                r_status[ST_V] <= w_add_v;
                            end
                            OP_SUB, OP_CMP: begin
                                if (w_op == OP_SUB) begin
                                    r_result <= w_diff[WIDTH-1:0];
                                end
                                r_status[ST_Z] <= ~|w_diff[WIDTH-1:0];
                                r_status[ST_N] <= w_diff[WIDTH-1];
                                r_status[ST_C] <= w_diff[WIDTH];
                                r_status[ST_V] <= w_sub_v;
                            end
                            OP_AND, OP_PASS, OP_SHL: begin
                                r_result       <= w_logic;
                                r_status[ST_Z] <= ~|w_logic;
                                r_status[ST_N] <= w_logic[WIDTH-1];
                            end
                            OP_MUL: begin
                                r_state <= StMul;
                                r_ready <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                StMul: begin
                    if (w_mul_valid) begin
                        r_hi           <= w_product[2*WIDTH-1:WIDTH];
                        r_lo           <= w_product[WIDTH-1:0];
                        r_status[ST_Z] <= ~|w_product;
                        r_status[ST_N] <= w_product[2*WIDTH-1];
                        r_done         <= 1'b1;
                        r_ready        <= 1'b1;
                        r_state        <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_hi     = r_hi;
    assign o_lo     = r_lo;
    assign o_status = r_status;

endmodule

// File: doc/seq_alu.md
# seq_alu

Registered, parametrised ALU for the datapath, successor to the combinational 16-bit ALU. It accepts one operation per start handshake and updates result, status and hi/lo registers. Single-cycle ops complete in one clock. Multiply runs on an iterative sub-unit, and the block is busy until it finishes. It sits between the register file read stage and write-back, and the controller sequences it with start/ready/done.

## Interface
- WIDTH, default 16: operand, result, hi and lo width (≥4, power of two).
- SHW, default $clog2(WIDTH): shift-amount width.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- op  input  3  opcode, sampled on accept.
- a, b  input  WIDTH  operands, sampled on accept.
- ready  output  1  block idle and can accept.
- done  output  1  one-cycle pulse: outputs updated for the accepted op.
- result  output  WIDTH  registered result.
- hi, lo  output  WIDTH  registered product upper and lower halves.
- status  output  16  flags: [15]=Z, [14]=N, [13]=C, [12]=V; bits [11:0] always 0.

## Operation
- Opcodes:
  - 000 NOP: result←0; flags unchanged.
  - 001 ADD: result←a+b.
  - 010 SUB: result←a−b.
  - 011 AND: result←a&b.
  - 100 PASS: result←b.
  - 101 SHL: result←a<<b. If b≥WIDTH, result is 0.
  - 110 MUL: {hi,lo}←a*b (2·WIDTH bits); result unchanged.
  - 111 CMP: computes a−b; only flags are written; result unchanged.
- Flags for ADD, SUB and CMP (two's complement):
  - Z = (r==0); N = r[WIDTH−1].
  - ADD: C = carry out of bit WIDTH−1; V = (a msb==b msb) && (r msb≠a msb).
  - SUB/CMP: C = borrow (a<b unsigned); V = (a msb≠b msb) && (r msb≠a msb).
- Flags for AND, PASS and SHL: Z and N are updated from result; C and V are held.
- Flags for MUL: Z = (full product==0), N = hi msb; C and V are held.
- Flags for NOP: all held.
- FSM states:
  - IDLE: ready=1. A start with op≠110 updates outputs and stays in IDLE. A start with op=110 goes to MUL.
  - MUL: ready=0. Runs WIDTH iteration cycles, then writes hi/lo/flags, pulses done and returns to IDLE.
- start while ready=0 is ignored. The request is not queued.
- Reset values: result, hi, lo and status are 0; done=0; ready=1; state=IDLE.
- A reset asserted mid-multiply aborts the operation. Partial products are discarded and no done pulse is issued.

## Timing
- Single-cycle op accepted at edge k: result/status are valid and done=1 during the cycle after edge k.
- Back-to-back single-cycle ops are allowed with start held high, one op per clock.
- MUL accepted at edge k:
  - ready=0 from edge k through edge k+WIDTH−1.
  - hi/lo/status are written at edge k+WIDTH, done=1 for that cycle, and ready=1 again.
  - Latency is WIDTH cycles (16 at the default).
- A start in the same cycle that done is high for a MUL is accepted, because ready is already 1.
- Outputs hold their value between operations.

## Configuration
- SEQ_ALU_SIGNED_MUL_EN defined: MUL treats a and b as two's complement. The sub-unit sign-corrects operands and product; Z and N are taken from the signed product.
- Undefined: MUL is unsigned. Latency is identical either way.

## Structure
- Package seq_alu_pkg holds:
  - the opcode enum (OP_NOP … OP_CMP);
  - status bit index constants (ST_Z=15, ST_N=14, ST_C=13, ST_V=12);
  - the FSM state typedef.
- Sub-module seq_alu_mul: iterative shift-add multiplier, WIDTH cycles.
  - Ports: clk, rst, go, a, b, busy, valid, product[2·WIDTH−1:0].
  - It owns the signed correction when SEQ_ALU_SIGNED_MUL_EN is defined.

## Test plan
All values are at WIDTH=16.
- Reset: rst held for 2 cycles → result=hi=lo=status=0, ready=1, done=0.
- ADD 0x7FFF+0x0001 → result 0x8000, N=1, V=1, C=0, Z=0, done one cycle after accept. ADD 0xFFFF+0x0001 → 0x0000, Z=1, C=1, V=0.
- SUB 0x0003−0x0005 → 0xFFFE, N=1, C=1. CMP 0x0005,0x0005 → Z=1, result keeps its prior 0xFFFE.
- SHL 0x0001 by 15 → 0x8000. SHL 0x0001 by 16 → 0x0000, Z=1.
- MUL 0x1234×0x0100 → hi 0x0012, lo 0x3400, done exactly 16 cycles after accept; a start during busy is ignored. MUL 0xFFFF×0x0002 → hi 0xFFFF, lo 0xFFFE with SEQ_ALU_SIGNED_MUL_EN; hi 0x0001, lo 0xFFFE without it.
- rst asserted 5 cycles into a MUL → next cycle all outputs 0, ready=1, no done pulse.
